// File: rtl/friet_pkg.sv
// rtl/friet_pkg.sv - shared constants, types and helpers for the protected Friet core
package friet_pkg;

  localparam int STATE_W = 384;
  localparam int LANE_W  = 128;
  localparam logic [4:0] RC_INIT = 5'b01111;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_INIT,
    ST_RUN,
    ST_CHECK,
    ST_UNLOAD
  } fsm_t;

  // Redundant four-limb state: d carries the parity a^b^c through every step.
  typedef struct packed {
    logic [LANE_W-1:0] d;
    logic [LANE_W-1:0] c;
    logic [LANE_W-1:0] b;
    logic [LANE_W-1:0] a;
  } lanes_t;

  function automatic int beats(input int b);
    return STATE_W / b;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] x, input int n);
    return (x << n) | (x >> (LANE_W - n));
  endfunction

  // The 5-bit constant is replicated into every 32-bit slice of the lane.
  function automatic logic [LANE_W-1:0] rc_expand(input logic [4:0] rc);
    return {4{27'd0, rc}};
  endfunction

endpackage

// File: rtl/friet_permutation_protected_round.sv
// rtl/friet_permutation_protected_round.sv - one Friet round on the parity-protected four-limb state
module friet_permutation_protected_round
  import friet_pkg::*;
(
  input  lanes_t     lanes,
  input  logic [4:0] rc_c,
  input  logic [4:0] rc_d,
  output lanes_t     lanes_next
);

  always_comb begin
    logic [LANE_W-1:0] a, b, c, d, t;
    a = lanes.a;
    b = lanes.b;
    c = lanes.c ^ rc_expand(rc_c);
    d = lanes.d ^ rc_expand(rc_d);
    // With the parity limb present, the limb-sum steps reduce to pure rewiring.
    {a, b, c, d} = {d, c, a, b};
    t = rotl(c, 1);
    b = b ^ t;
    d = d ^ t;
    t = rotl(b, 80);
    c = c ^ t;
    d = d ^ t;
    {b, d} = {d, b};
    t = rotl(b, 36) & rotl(c, 67);
    a = a ^ t;
    d = d ^ t;
    lanes_next = '{d: d, c: c, b: b, a: a};
  end

endmodule

// File: rtl/friet_permutation_rc.sv
// rtl/friet_permutation_rc.sv - one step of the 5-bit round-constant LFSR
module friet_permutation_rc (
  input  logic [4:0] rc,
  output logic [4:0] rc_next
);

  assign rc_next = {rc[3:0], rc[4] ^ rc[2]};

endmodule

// File: rtl/friet_protected_round_chain.sv
// rtl/friet_protected_round_chain.sv - combinational chain of protected rounds with duplicated rc sequencing
module friet_protected_round_chain
  import friet_pkg::*;
#(
  parameter int COMBINATIONAL_ROUNDS = 1
) (
  input  lanes_t     lanes,
  input  logic [4:0] rc_c,
  input  logic [4:0] rc_d,
  output lanes_t     lanes_next,
  output logic [4:0] rc_c_next,
  output logic [4:0] rc_d_next
);

  for (genvar g = 0; g < COMBINATIONAL_ROUNDS; g++) begin : g_stage
    lanes_t     l_in, l_out;
    logic [4:0] rcc_in, rcd_in, rcc_out, rcd_out;

    if (g == 0) begin : g_first
      assign l_in   = lanes;
      assign rcc_in = rc_c;
      assign rcd_in = rc_d;
    end else begin : g_next
      assign l_in   = g_stage[g-1].l_out;
      assign rcc_in = g_stage[g-1].rcc_out;
      assign rcd_in = g_stage[g-1].rcd_out;
    end

    friet_permutation_protected_round u_round (
      .lanes      (l_in),
      .rc_c       (rcc_in),
      .rc_d       (rcd_in),
      .lanes_next (l_out)
    );

    friet_permutation_rc u_rc_c (.rc(rcc_in), .rc_next(rcc_out));
    friet_permutation_rc u_rc_d (.rc(rcd_in), .rc_next(rcd_out));
  end

  assign lanes_next = g_stage[COMBINATIONAL_ROUNDS-1].l_out;
  assign rc_c_next  = g_stage[COMBINATIONAL_ROUNDS-1].rcc_out;
  assign rc_d_next  = g_stage[COMBINATIONAL_ROUNDS-1].rcd_out;

endmodule

// File: rtl/friet_permutation_protected_stream_core.sv
// rtl/friet_permutation_protected_stream_core.sv - streaming fault-protected Friet permutation core
module friet_permutation_protected_stream_core
  import friet_pkg::*;
#(
  parameter int BUFFER_LENGTH        = 32,
  parameter int COMBINATIONAL_ROUNDS = 1,
  parameter int TOTAL_ROUNDS         = 24,
  parameter int ZEROIZE_ON_FAULT     = 1
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BUFFER_LENGTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BUFFER_LENGTH-1:0] out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     fault
);

  localparam int B     = BUFFER_LENGTH;
  localparam int BEATS = beats(B);
  localparam int R     = TOTAL_ROUNDS / COMBINATIONAL_ROUNDS;
  localparam int BCW   = clog2(BEATS);
  localparam int RCW   = clog2(R);
  localparam logic [BCW-1:0] BEAT_LAST  = BCW'(BEATS - 1);
  localparam logic [RCW-1:0] ROUND_LAST = RCW'(R - 1);

  fsm_t st_q, st_d;
  logic [STATE_W-1:0] state_q;
  (* dont_touch = "true" *) logic [LANE_W-1:0] parity_q;
  (* dont_touch = "true" *) logic fault_q;
  logic [4:0]     rc_c_q, rc_d_q, rc_c_nx, rc_d_nx;
  logic [BCW-1:0] beat_cnt_q;
  logic [RCW-1:0] round_cnt_q;
  lanes_t         lanes_nx;
  logic [STATE_W-1:0] load_shift, unload_rot;
  logic in_fire, out_fire, par_err, rc_err, fault_final;

  assign in_fire     = in_valid & in_ready & ~abort;
  assign out_fire    = out_valid & out_ready & ~abort;
  assign par_err     = |(state_q[127:0] ^ state_q[255:128] ^ state_q[383:256] ^ parity_q);
  assign rc_err      = rc_c_q != rc_d_q;
  assign fault_final = fault_q | par_err;
  assign load_shift  = STATE_W'({in_data, state_q} >> B);
  assign unload_rot  = STATE_W'({state_q, state_q} >> B);
  assign out_data    = state_q[B-1:0];
  assign fault       = fault_q;

  friet_protected_round_chain #(.COMBINATIONAL_ROUNDS(COMBINATIONAL_ROUNDS)) u_chain (
    .lanes      (lanes_t'({parity_q, state_q})),
    .rc_c       (rc_c_q),
    .rc_d       (rc_d_q),
    .lanes_next (lanes_nx),
    .rc_c_next  (rc_c_nx),
    .rc_d_next  (rc_d_nx)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) st_q <= ST_LOAD;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (abort) begin
      st_d = ST_LOAD;
    end else begin
      case (st_q)
        ST_LOAD:   if (in_fire && beat_cnt_q == BEAT_LAST) st_d = ST_INIT;
        ST_INIT:   st_d = ST_RUN;
        ST_RUN:    if (round_cnt_q == ROUND_LAST) st_d = ST_CHECK;
        ST_CHECK:  st_d = ST_UNLOAD;
        ST_UNLOAD: if (out_fire && beat_cnt_q == BEAT_LAST) st_d = ST_LOAD;
        default:   st_d = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready  = st_q == ST_LOAD;
    out_valid = st_q == ST_UNLOAD;
    busy      = (st_q == ST_INIT) | (st_q == ST_RUN) | (st_q == ST_CHECK);
    done      = (st_q == ST_CHECK) & ~abort;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_q  <= '0;
      round_cnt_q <= '0;
      fault_q     <= 1'b0;
      rc_c_q      <= RC_INIT;
      rc_d_q      <= RC_INIT;
    end else if (abort) begin
      beat_cnt_q  <= '0;
      round_cnt_q <= '0;
      fault_q     <= 1'b0;
      rc_c_q      <= RC_INIT;
      rc_d_q      <= RC_INIT;
    end else begin
      case (st_q)
        ST_LOAD:
          if (in_fire) beat_cnt_q <= (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BCW'(1);
        ST_INIT: begin
          round_cnt_q <= '0;
          fault_q     <= 1'b0;
          rc_c_q      <= RC_INIT;
          rc_d_q      <= RC_INIT;
        end
        ST_RUN: begin
          rc_c_q      <= rc_c_nx;
          rc_d_q      <= rc_d_nx;
          fault_q     <= fault_q | par_err | rc_err;
          round_cnt_q <= (round_cnt_q == ROUND_LAST) ? '0 : round_cnt_q + RCW'(1);
        end
        ST_CHECK: fault_q <= fault_final;
        ST_UNLOAD:
          if (out_fire) beat_cnt_q <= (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + BCW'(1);
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; abort still scrubs them synchronously.
  always_ff @(posedge clk) begin
    if (abort) begin
      state_q  <= '0;
      parity_q <= '0;
    end else begin
      case (st_q)
        ST_LOAD:   if (in_fire) state_q <= load_shift;
        ST_INIT:   parity_q <= state_q[127:0] ^ state_q[255:128] ^ state_q[383:256];
        ST_RUN: begin
          state_q  <= {lanes_nx.c, lanes_nx.b, lanes_nx.a};
          parity_q <= lanes_nx.d;
        end
        ST_CHECK:  if (ZEROIZE_ON_FAULT != 0 && fault_final) state_q <= '0;
        ST_UNLOAD: if (out_fire) state_q <= unload_rot;
        default: ;
      endcase
    end
  end

endmodule
